// File: rtl/hash_ctrl_pkg.sv
// rtl/hash_ctrl_pkg.sv - shared state encoding and default geometry for the hash round controller
package hash_ctrl_pkg;

    localparam int DEF_N_ITER   = 8;
    localparam int DEF_N_ROUNDS = 12;
    localparam int DEF_CNT_W    = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/hash_round_cnt.sv
// rtl/hash_round_cnt.sv - iteration/round counter pair with clear, finalisation preset and wrap/last flags
module hash_round_cnt
    import hash_ctrl_pkg::*;
#(
    parameter int N_ITER   = DEF_N_ITER,
    parameter int N_ROUNDS = DEF_N_ROUNDS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_en,
    input  logic                        i_round_en,
    input  logic                        i_clr,
    input  logic                        i_set_fin,
    output logic [$clog2(N_ITER)-1:0]   o_iter,
    output logic [$clog2(N_ROUNDS):0]   o_round,
    output logic                        o_wrap,
    output logic                        o_last
);

    localparam int IW = $clog2(N_ITER);
    localparam int RW = $clog2(N_ROUNDS) + 1;
    localparam logic [IW-1:0] ITER_MAX   = IW'(N_ITER - 1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(N_ROUNDS - 1);
    localparam logic [RW-1:0] ROUND_FIN  = RW'(N_ROUNDS);

    logic [IW-1:0] r_iter;
    logic [RW-1:0] r_round;

    assign o_wrap  = (r_iter == ITER_MAX);
    assign o_last  = o_wrap && (r_round == ROUND_LAST);
    assign o_iter  = r_iter;
    assign o_round = r_round;

    // Round only advances on wrap when i_round_en; during finalisation it stays parked at N_ROUNDS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iter  <= '0;
            r_round <= '0;
        end else if (i_clr) begin
            r_iter  <= '0;
            r_round <= '0;
        end else if (i_set_fin) begin
            r_iter  <= '0;
            r_round <= ROUND_FIN;
        end else if (i_en) begin
            if (o_wrap) begin
                r_iter <= '0;
                if (i_round_en) begin
                    r_round <= r_round + 1'b1;
                end
            end else begin
                r_iter <= r_iter + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hash_round_ctrl.sv
// rtl/hash_round_ctrl.sv - block load / round / finalisation sequencer for an iterative hash core
module hash_round_ctrl
    import hash_ctrl_pkg::*;
#(
    parameter int N_ITER   = DEF_N_ITER,
    parameter int N_ROUNDS = DEF_N_ROUNDS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        F_dr,
    input  logic                        End_Of_File,
    input  logic                        H_ack,
    output logic                        F_rtr,
    output logic                        validate_input,
    output logic                        validate_R_H,
    output logic                        switch_operation,
    output logic                        H_ready,
    output logic [$clog2(N_ITER)-1:0]   I,
    output logic [$clog2(N_ROUNDS):0]   round,
    output logic                        busy,
    output logic [CNT_W-1:0]            blk_cnt,
    output logic                        cnt_ovf
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_f_rtr;
    logic               r_switch;
    logic               r_h_ready;
    logic               r_busy;
    logic               r_eof_flag;
    logic               r_cnt_ovf;
    logic [CNT_W-1:0]   r_blk_cnt;

    logic w_wrap;
    logic w_last;
    logic w_load;
    logic w_start;
    logic w_cnt_clr;
    logic w_cnt_en;
    logic w_set_fin;
    logic w_round_en;

    assign validate_input = F_dr & r_f_rtr;
    assign w_load         = validate_input & ~abort;
    assign w_start        = (r_state == S_IDLE) & start & ~abort;

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_state_nxt = S_LOAD;
                S_LOAD: begin
                    if (F_dr)             w_state_nxt = S_ROUND;
                    else if (End_Of_File) w_state_nxt = S_FINAL;
                end
                S_ROUND: if (w_last) w_state_nxt = r_eof_flag ? S_FINAL : S_LOAD;
                S_FINAL: if (w_wrap) w_state_nxt = S_OUT;
                S_OUT:   if (H_ack)  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Counters are zero whenever the next state is IDLE/LOAD; an empty message jumps straight to FINAL.
    assign w_cnt_clr  = (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
    assign w_set_fin  = (r_state == S_LOAD) && (w_state_nxt == S_FINAL);
    assign w_cnt_en   = (r_state == S_ROUND) || (r_state == S_FINAL);
    assign w_round_en = (r_state == S_ROUND);

    hash_round_cnt #(
        .N_ITER   (N_ITER),
        .N_ROUNDS (N_ROUNDS)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_cnt_en),
        .i_round_en (w_round_en),
        .i_clr      (w_cnt_clr),
        .i_set_fin  (w_set_fin),
        .o_iter     (I),
        .o_round    (round),
        .o_wrap     (w_wrap),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_f_rtr   <= 1'b0;
            r_switch  <= 1'b0;
            r_h_ready <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_f_rtr   <= (w_state_nxt == S_LOAD);
            r_switch  <= (w_state_nxt == S_FINAL);
            r_h_ready <= (w_state_nxt == S_OUT);
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    // Count and overflow survive abort so software can inspect them until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_cnt  <= '0;
            r_cnt_ovf  <= 1'b0;
            r_eof_flag <= 1'b0;
        end else if (w_start) begin
            r_blk_cnt  <= '0;
            r_cnt_ovf  <= 1'b0;
            r_eof_flag <= 1'b0;
        end else if (w_load) begin
            r_eof_flag <= End_Of_File;
            if (r_blk_cnt == '1) begin
                r_cnt_ovf <= 1'b1;
            end else begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
            end
        end
    end

    assign F_rtr            = r_f_rtr;
    assign switch_operation = r_switch;
    assign validate_R_H     = validate_input | r_switch;
    assign H_ready          = r_h_ready;
    assign busy             = r_busy;
    assign blk_cnt          = r_blk_cnt;
    assign cnt_ovf          = r_cnt_ovf;

endmodule

// File: doc/hash_round_ctrl.md
HASH_ROUND_CTRL -- requirements
Module: hash_round_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_ITER, 8, iterations per round; power of two, >= 2.
- N_ROUNDS, 12, rounds per block; >= 1.
- CNT_W, 16, block-counter width.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin new message; honoured only in IDLE.
- abort  in  1  synchronous return to IDLE from any state.
- F_dr  in  1  input block valid.
- End_Of_File  in  1  last-block/end-of-message flag, qualified as in REQ-007/008.
- H_ack  in  1  consumer accepts digest.
- F_rtr  out  1  ready to receive a block.
- validate_input  out  1  block load strobe = F_dr & F_rtr.
- validate_R_H  out  1  state-register update = validate_input | switch_operation.
- switch_operation  out  1  finalisation phase active.
- H_ready  out  1  digest valid.
- I  out  $clog2(N_ITER)  iteration index.
- round  out  $clog2(N_ROUNDS)+1  round index.
- busy  out  1  state != IDLE.
- blk_cnt  out  CNT_W  blocks accepted in current message.
- cnt_ovf  out  1  sticky block-counter saturation flag.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, ROUND, FINAL, OUT; all outputs Moore except validate_input and validate_R_H.
REQ-004 IDLE: start=1 -> LOAD next cycle; blk_cnt, cnt_ovf, eof_flag cleared on that transition.
REQ-005 LOAD: F_rtr=1; I=0, round=0 held.
REQ-006 LOAD with F_dr=1: validate_input=1 for exactly that cycle; eof_flag <= End_Of_File; blk_cnt +1; -> ROUND.
REQ-007 LOAD with F_dr=0 and End_Of_File=1 (empty message or end marker without data): -> FINAL; blk_cnt unchanged.
REQ-008 LOAD with F_dr=0 and End_Of_File=0: remain in LOAD indefinitely.
REQ-009 ROUND: I increments every cycle; at I==N_ITER-1, I wraps to 0 and round increments.
REQ-010 ROUND exit on I==N_ITER-1 and round==N_ROUNDS-1: -> FINAL if eof_flag, else -> LOAD. Each block therefore occupies exactly N_ITER*N_ROUNDS cycles in ROUND.
REQ-011 FINAL: switch_operation=1; I counts 0..N_ITER-1; round=N_ROUNDS; after I==N_ITER-1 -> OUT (N_ITER cycles total).
REQ-012 OUT: H_ready=1 until H_ack=1; H_ack=1 -> IDLE next cycle; H_ack outside OUT ignored.
REQ-013 start outside IDLE SHALL be ignored; F_dr outside LOAD SHALL be ignored (F_rtr=0, no load).
REQ-014 abort SHALL take priority over every other input: -> IDLE next cycle, I=0, round=0; blk_cnt and cnt_ovf hold their values until the next start.
REQ-015 blk_cnt SHALL saturate at 2^CNT_W-1; an increment attempted at saturation sets cnt_ovf, which stays set until the next start.
REQ-016 Outside ROUND/FINAL, I SHALL be 0; round SHALL be 0 in IDLE/LOAD and N_ROUNDS in OUT.

Reset
REQ-017 rst_n=0 SHALL asynchronously force IDLE, I=0, round=0, blk_cnt=0, cnt_ovf=0, eof_flag=0.
REQ-018 During reset, F_rtr, validate_input, validate_R_H, switch_operation, H_ready and busy SHALL all be 0.
REQ-019 Reset asserted mid-operation SHALL discard the message; the first cycle after release is IDLE.

Structure
REQ-020 Package hash_ctrl_pkg SHALL hold the state enum and the default N_ITER/N_ROUNDS/CNT_W constants.
REQ-021 The iteration/round counter pair SHALL be one sub-module, hash_round_cnt, with enable, clear and wrap/last outputs.

Verification
REQ-022 Defaults. start, then one block with F_dr=1 and End_Of_File=1 -> validate_input pulses once; 96 ROUND cycles; 8 FINAL cycles; H_ready=1; H_ack -> IDLE; blk_cnt=1.
REQ-023 Three blocks, End_Of_File=1 on the third only -> F_rtr reasserts exactly 96 cycles after each accept; FINAL only after block 3; blk_cnt=3.
REQ-024 start, then End_Of_File=1 with F_dr=0 in LOAD -> FINAL immediately; H_ready after 8 cycles; blk_cnt=0.
REQ-025 abort at round=5, I=3 -> IDLE next cycle; H_ready never asserts; a new start works normally.
REQ-026 CNT_W=2, five non-final blocks -> blk_cnt sticks at 3 and cnt_ovf=1; a new start clears both.
REQ-027 rst_n low mid-FINAL, and H_ack held high before OUT -> all outputs 0 in reset; IDLE after release; early H_ack has no effect.
